oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 97 +++++++++
 1 files changed

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to the trigger address halts the CPU and copies one
// 256-byte page to the PPU OAM data port as 256 read/write cycle pairs.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_write,
  input  logic [7:0]  bus_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_write
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e      state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        rdy_q, rdy_d;
  logic        dma_active_q, dma_active_d;
  logic        bus_write_q, bus_write_d;
  logic [15:0] bus_addr_q, bus_addr_d;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (cpu_write && (cpu_addr == TRIGGER_ADDR)) begin
          page_d  = cpu_data;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      // A HALT on a get cycle lets READ start immediately; otherwise burn one cycle.
      StHalt:  state_d = parity_q ? StAlign : StRead;
      StAlign: state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? StIdle : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are driven straight from flops.
  always_comb begin
    rdy_d        = (state_d == StIdle);
    dma_active_d = (state_d != StIdle);
    bus_write_d  = (state_d == StWrite);
    bus_addr_d   = 16'h0000;
    if (state_d == StRead) begin
      bus_addr_d = {page_d, idx_d};
    end else if (state_d == StWrite) begin
      bus_addr_d = OAM_DATA_ADDR;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      parity_q     <= 1'b0;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      rdy_q        <= 1'b1;
      dma_active_q <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      parity_q     <= ~parity_q;
      page_q       <= page_d;
      idx_q        <= idx_d;
      rdy_q        <= rdy_d;
      dma_active_q <= dma_active_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
    end
  end

  assign rdy          = rdy_q;
  assign dma_active   = dma_active_q;
  assign bus_write    = bus_write_q;
  assign bus_addr     = bus_addr_q;
  // Read data arrives the cycle after READ, so it is forwarded unregistered in WRITE.
  assign bus_data_out = (state_q == StWrite) ? bus_data_in : 8'h00;

endmodule
